// File: rtl/ahb_rr_arbiter.sv
// N-way AHB bus arbiter: round-robin or fixed priority, burst hold, re-arbitration at Advance.
// Grant, GrantIdx and GrantValid are registered and update together.
module ahb_rr_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned IDXW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic [N-1:0]    Req,
  input  logic [N-1:0]    Hold,
  input  logic            Advance,
  output logic [N-1:0]    Grant,
  output logic [IDXW-1:0] GrantIdx,
  output logic            GrantValid
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;

  logic            found;
  logic [IDXW-1:0] win_idx;
  logic [N-1:0]    win_oh;
  logic [IDXW-1:0] nxt_ptr;
  logic            own_hold;
  logic            arb_en;
  int unsigned     ptr_u;
  int unsigned     pos;
  int unsigned     best_pos;

  // Winner is the requester with the smallest rotated distance from ptr;
  // fixed mode keeps ptr at 0, so the same search yields the lowest index.
  always_comb begin
    ptr_u    = {{(32-IDXW){1'b0}}, ptr};
    pos      = 0;
    best_pos = N;
    win_idx  = '0;
    win_oh   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (i >= ptr_u) ? (i - ptr_u) : (i + N - ptr_u);
      if (Req[i] && (pos < best_pos)) begin
        best_pos   = pos;
        win_idx    = IDXW'(i);
        win_oh     = '0;
        win_oh[i]  = 1'b1;
      end
    end
    found = (best_pos < N);
  end

  always_comb begin
    nxt_ptr = '0;
    if (ROUND_ROBIN != 0) begin
      if ({{(32-IDXW){1'b0}}, win_idx} == N - 1) nxt_ptr = '0;
      else                                     nxt_ptr = win_idx + 1'b1;
    end
  end

  // Grant is one-hot, so masking avoids indexing Req/Hold by GrantIdx.
  assign own_hold = |(Grant & Req & Hold);
  assign arb_en   = (state == IDLE) || (Advance && !own_hold);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      ptr        <= '0;
      Grant      <= '0;
      GrantIdx   <= '0;
      GrantValid <= 1'b0;
    end else if (arb_en) begin
      if (found) begin
        state      <= OWNED;
        ptr        <= nxt_ptr;
        Grant      <= win_oh;
        GrantIdx   <= win_idx;
        GrantValid <= 1'b1;
      end else begin
        state      <= IDLE;
        Grant      <= '0;
        GrantIdx   <= '0;
        GrantValid <= 1'b0;
      end
    end
  end

  a_grant_onehot: assert property (@(posedge HCLK) $onehot0(Grant));
  a_valid_match:  assert property (@(posedge HCLK) GrantValid == (|Grant));
  a_idx_match:    assert property (@(posedge HCLK)
                    Grant == (GrantValid ? (N'(1) << GrantIdx) : N'(0)));

endmodule
